// File: rtl/bus_pkg.sv
// Shared bus command encoding, UART register offsets and serializer state type.
// Used by the CPU bus slaves and their testbenches.
package bus_pkg;

    typedef enum logic [1:0] {
        bus_cmd_nop   = 2'd0,
        bus_cmd_read  = 2'd1,
        bus_cmd_write = 2'd2
    } bus_cmd_t;

    localparam logic [1:0] UART_DATA_OFS   = 2'd0;
    localparam logic [1:0] UART_STATUS_OFS = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // STATUS layout: occupancy in [15:8], busy in [1], full in [0].
    function automatic logic [15:0] uart_status_word(input logic       full,
                                                     input logic       busy,
                                                     input logic [7:0] occ);
        return {occ, 6'b000000, busy, full};
    endfunction

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// Generic synchronous FIFO, registered count; push ignored when full, pop ignored when empty.
// Head data is presented combinationally from storage; push and pop may share an edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Acceptance uses registered occupancy, so a full FIFO refuses a push even when popping.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Toggle-handshake bus slave that queues bytes and serializes them 8N1 on tx.
// Bus latency 1 edge; DATA writes to a full FIFO stall (done withheld) until a pop frees space.
module bus_uart_tx
    import bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [1:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [15:0]   rd_data_q, rd_data_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pending;
    logic          busy;
    logic          baud_wrap;
    bus_cmd_t      cmd_e;
    logic          unused_bits;

    assign unused_bits = ^{addr[15:2], wr_data[15:8]};

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fifo_push),
        .push_dat_i(wr_data[7:0]),
        .pop_i     (fifo_pop),
        .pop_dat_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign pending   = (run != done_q);
    assign cmd_e     = bus_cmd_t'(cmd);
    assign busy      = !fifo_empty || (state_q != IDLE);
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        done_d    = done_q;
        rd_data_d = rd_data_q;
        fifo_push = 1'b0;
        if (pending) begin
            case (cmd_e)
                bus_cmd_read: begin
                    done_d = ~done_q;
                    if (addr[1:0] == UART_STATUS_OFS) begin
                        rd_data_d = uart_status_word(fifo_full, busy, 8'(fifo_count));
                    end else begin
                        rd_data_d = '0;
                    end
                end
                bus_cmd_write: begin
                    if (addr[1:0] == UART_DATA_OFS) begin
                        // Holding done back is the stall the CPU sees.
                        if (!fifo_full) begin
                            fifo_push = 1'b1;
                            done_d    = ~done_q;
                        end
                    end else begin
                        done_d = ~done_q;
                    end
                end
                default: begin
                    done_d = ~done_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    // Chaining straight into START keeps queued frames contiguous.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_bus_uart_tx;

    localparam int CPB = 4;
    localparam logic [1:0] C_NOP = 2'd0;
    localparam logic [1:0] C_RD  = 2'd1;
    localparam logic [1:0] C_WR  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [1:0]  cmd;
    logic        run;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .cmd    (cmd),
        .run    (run),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .done   (done),
        .tx     (tx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
        cmd     = c;
        addr    = a;
        wr_data = d;
        run     = ~run;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; cmd = C_NOP; addr = '0; wr_data = '0;
        tick(); tick();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rd: got %h want 0000", rd_data); end
        reset = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_idle_done: got %b want 0", done); end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        issue(C_WR, 16'd0, 16'h0055);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL sb_done: got %b want %b", done, run); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL sb_tx_pre: got %b want 1", tx); end
        tick();
        for (int i = 0; i < 10 * CPB; i++) begin
            n_checks++;
            if (tx !== fr[i / CPB]) begin n_fail++; $display("FAIL sb_bit cyc %0d: got %b want %b", i, tx, fr[i / CPB]); end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL sb_idle cyc %0d: got %b want 1", i, tx); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] seq;
        seq = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        issue(C_WR, 16'd0, 16'h0000);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL b2b_done0: got %b want %b", done, run); end
        issue(C_WR, 16'd0, 16'h00FF);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL b2b_done1: got %b want %b", done, run); end
        for (int i = 0; i < 20 * CPB; i++) begin
            n_checks++;
            if (tx !== seq[i / CPB]) begin n_fail++; $display("FAIL b2b_bit cyc %0d: got %b want %b", i, tx, seq[i / CPB]); end
            if (i == 21) begin
                n_checks++; if (rd_data !== 16'h0102) begin n_fail++; $display("FAIL b2b_stat1: got %h want 0102", rd_data); end
            end
            if (i == 61) begin
                n_checks++; if (rd_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_stat2: got %h want 0002", rd_data); end
            end
            if (i == 20 || i == 60) issue(C_RD, 16'd1, 16'h0000);
            tick();
        end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_end: got %b want 1", tx); end
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL b2b_idle_stat: got %h want 0000", rd_data); end
    endtask

    task automatic test_full_stall();
        int waited;
        issue(C_WR, 16'd0, 16'h000F);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL fs_done0: got %b want %b", done, run); end
        repeat (6) tick();
        for (int k = 0; k < 4; k++) begin
            issue(C_WR, 16'd0, 16'(16'h0010 + k));
            tick();
            n_checks++; if (done !== run) begin n_fail++; $display("FAIL fs_wr%0d: got %b want %b", k + 1, done, run); end
        end
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0403) begin n_fail++; $display("FAIL fs_stat: got %h want 0403", rd_data); end
        issue(C_WR, 16'd0, 16'h00A5);
        tick();
        waited = 1;
        n_checks++; if (done === run) begin n_fail++; $display("FAIL fs_stall: done=%b completed, want still pending", done); end
        while (done !== run && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++; if (waited != 31) begin n_fail++; $display("FAIL fs_stall_len: got %0d edges want 31", waited); end
        repeat (210) tick();
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL fs_drain: got %h want 0000", rd_data); end
    endtask

    task automatic test_status_reserved();
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL sr_idle: got %h want 0000", rd_data); end
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL sr_idle_done: got %b want %b", done, run); end
        issue(C_WR, 16'd0, 16'h003C);
        tick();
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0102) begin n_fail++; $display("FAIL sr_busy1: got %h want 0102", rd_data); end
        issue(C_RD, 16'd0, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL sr_data_rd: got %h want 0000", rd_data); end
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0002) begin n_fail++; $display("FAIL sr_busy2: got %h want 0002", rd_data); end
        issue(C_RD, 16'd3, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL sr_rsvd_rd: got %h want 0000", rd_data); end
        repeat (45) tick();
        issue(C_WR, 16'd2, 16'h0000);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL sr_rsvd_wr_done: got %b want %b", done, run); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL sr_rsvd_wr_tx: got %b want 1", tx); end
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL sr_rsvd_stat: got %h want 0000", rd_data); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL sr_rsvd_tx2: got %b want 1", tx); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        issue(C_WR, 16'd0, 16'h0000);
        tick();
        issue(C_WR, 16'd0, 16'h0011);
        tick();
        issue(C_WR, 16'd0, 16'h0022);
        tick();
        repeat (16) tick();
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rm_bit3: got %b want 0", tx); end
        reset = 1'b1; run = 1'b0; cmd = C_NOP;
        tick();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rm_tx: got %b want 1", tx); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b want 0", done); end
        reset = 1'b0;
        tick();
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rm_stat: got %h want 0000", rd_data); end
        bad = 0;
        repeat (100) begin
            if (tx !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rm_quiet: %0d cycles with tx low, want 0", bad); end
    endtask

    task automatic test_nop();
        issue(C_NOP, 16'd0, 16'h00AB);
        tick();
        n_checks++; if (done !== run) begin n_fail++; $display("FAIL nop_done: got %b want %b", done, run); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL nop_tx: got %b want 1", tx); end
        repeat (3) tick();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL nop_tx_later: got %b want 1", tx); end
        issue(C_RD, 16'd1, 16'h0000);
        tick();
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL nop_stat: got %h want 0000", rd_data); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_stall();
        test_status_reserved();
        test_reset_midframe();
        test_nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
